hazard_scoreboard: RTL and testbench

- Issue-stage interlock controller that sits between decode and the register-read/execute stages.
- Tracks in-flight register writes with per-register countdown counters and sequences the multi-cycle DIV/DIVU unit with a two-state FSM.
- Asserts stall to hold the decoded instruction until its sources and the HI/LO resource are available.
- Decode consumes stall as its issue gate; the scoreboard updates only on a fire (issue_valid & !stall & !flush).

---
 rtl/hazard_scoreboard_pkg.sv | 15 +
 rtl/hazard_div_seq.sv | 58 +++++
 rtl/hazard_scoreboard.sv | 89 ++++++++
 tb/tb_hazard_scoreboard.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the issue-stage hazard scoreboard.
package hazard_scoreboard_pkg;

   localparam int unsigned REG_IDX_W    = 5;
   localparam int unsigned LOAD_LAT_DEF = 3;
   localparam int unsigned ALU_LAT_DEF  = 1;
   localparam int unsigned DIV_LAT_DEF  = 32;

   // Divide sequencer states
   typedef enum logic {
      HZ_IDLE = 1'b0,
      HZ_BUSY = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hazard_div_seq.sv
// Divide sequencer: holds the HI/LO unit busy for DIV_LAT cycles after a DIV
// issues, then pulses div_done for one cycle.
module hazard_div_seq
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic div_busy,
   output logic div_done
);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic             done_q, done_d;

   // Next-state logic: load the count on start, count down while busy
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      done_d    = 1'b0;
      unique case (state_q)
         HZ_IDLE: begin
            if (start) begin
               state_d   = HZ_BUSY;
               div_cnt_d = CNT_W'(DIV_LAT);
            end
         end
         HZ_BUSY: begin
            div_cnt_d = div_cnt_q - CNT_W'(1);
            if (div_cnt_q == CNT_W'(1)) begin
               state_d = HZ_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HZ_IDLE;
         div_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         done_q    <= done_d;
      end
   end

   assign div_busy = (state_q == HZ_BUSY);
   assign div_done = done_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage interlock: per-register countdown scoreboard plus HI/LO divide
// tracking. Define HAZARD_FWD_EN when the bypass network can supply a value
// whose counter has reached 1.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
   parameter int unsigned ALU_LAT  = ALU_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_valid,
   input  logic [REG_IDX_W-1:0] issue_rs,
   input  logic [REG_IDX_W-1:0] issue_rt,
   input  logic                 issue_uses_rs,
   input  logic                 issue_uses_rt,
   input  logic [REG_IDX_W-1:0] issue_dst,
   input  logic                 issue_dst_we,
   input  logic                 issue_is_load,
   input  logic                 issue_is_div,
   input  logic                 issue_reads_hilo,
   input  logic                 flush,
   output logic                 stall,
   output logic                 div_busy,
   output logic                 div_done,
   output logic [NUM_REGS-1:0]  pend_mask
);

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];
   logic [CNT_W-1:0] new_lat;
   logic             rs_hz, rt_hz, hilo_hz, fire;

   // A source is unavailable while its producer is still too far away
   function automatic logic hz(input logic [CNT_W-1:0] c);
`ifdef HAZARD_FWD_EN
      return c > CNT_W'(1);
`else
      return c != '0;
`endif
   endfunction

   // Interlock decision; stall is held high throughout reset
   always_comb begin
      rs_hz   = issue_uses_rs && (issue_rs != '0) && hz(cnt_q[issue_rs]);
      rt_hz   = issue_uses_rt && (issue_rt != '0) && hz(cnt_q[issue_rt]);
      hilo_hz = (issue_is_div || issue_reads_hilo) && div_busy;
      stall   = !rst_n || (issue_valid && !flush && (rs_hz || rt_hz || hilo_hz));
      fire    = issue_valid && !stall && !flush;
      new_lat = issue_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
   end

   // Counter next state: age every entry, then keep the longer of old/new on a write
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
         if (fire && issue_dst_we && (r != 0) && (issue_dst == REG_IDX_W'(r))
             && (new_lat > cnt_d[r])) begin
            cnt_d[r] = new_lat;
         end
         pend_mask[r] = (cnt_q[r] != '0);
      end
      cnt_d[0] = '0;
   end

   // Counter array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      end
   end

   hazard_div_seq #(
      .CNT_W   (CNT_W),
      .DIV_LAT (DIV_LAT)
   ) u_div_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (fire && issue_is_div),
      .div_busy (div_busy),
      .div_done (div_done)
   );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Expectations follow HAZARD_FWD_EN.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
   localparam int A_STALLS   = 2;
   localparam int B_STALL    = 0;
   localparam int WAW_STALLS = 1;
`else
   localparam int A_STALLS   = 3;
   localparam int B_STALL    = 1;
   localparam int WAW_STALLS = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_uses_rs, issue_uses_rt, issue_dst_we;
   logic        issue_is_load, issue_is_div, issue_reads_hilo, flush;
   logic [4:0]  issue_rs, issue_rt, issue_dst;
   logic        stall, div_busy, div_done;
   logic [31:0] pend_mask;

   int errors = 0;
   int checks = 0;

   hazard_scoreboard dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .issue_valid      (issue_valid),
      .issue_rs         (issue_rs),
      .issue_rt         (issue_rt),
      .issue_uses_rs    (issue_uses_rs),
      .issue_uses_rt    (issue_uses_rt),
      .issue_dst        (issue_dst),
      .issue_dst_we     (issue_dst_we),
      .issue_is_load    (issue_is_load),
      .issue_is_div     (issue_is_div),
      .issue_reads_hilo (issue_reads_hilo),
      .flush            (flush),
      .stall            (stall),
      .div_busy         (div_busy),
      .div_done         (div_done),
      .pend_mask        (pend_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction, then let combinational outputs settle
   task automatic pres(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic we, input logic ld, input logic dv, input logic hl,
                       input logic fl);
      issue_valid = v;   issue_rs = rs;  issue_rt = rt;
      issue_uses_rs = urs; issue_uses_rt = urt;
      issue_dst = dst;   issue_dst_we = we; issue_is_load = ld;
      issue_is_div = dv; issue_reads_hilo = hl; flush = fl;
      #1;
   endtask

   task automatic nop();
      pres(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      nop();
      repeat (4) cyc();
      chk(tag, pend_mask, 32'h0);
   endtask

   initial begin
      // Reset with an instruction presented
      rst_n = 1'b0;
      pres(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_stall", {31'b0, stall}, 32'd1);
      chk("rst_busy", {31'b0, div_busy}, 32'd0);
      chk("rst_done", {31'b0, div_done}, 32'd0);
      chk("rst_pend", pend_mask, 32'h0);
      cyc();
      cyc();
      rst_n = 1'b1;
      nop();
      chk("post_rst_stall", {31'b0, stall}, 32'd0);

      // LW r2 then ADD r3,r2,r1
      pres(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lw_fire", {31'b0, stall}, 32'd0);
      cyc();
      for (int c = 1; c <= A_STALLS + 1; c++) begin
         pres(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("lwuse_stall_c%0d", c), {31'b0, stall}, (c <= A_STALLS) ? 32'd1 : 32'd0);
         if (c == 1) chk("lwuse_pend_c1", pend_mask, 32'h4);
         cyc();
      end
      drain("drain_a");

      // ADDIU r5 then SUB r6,r5,r5
      pres(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("addiu_fire", {31'b0, stall}, 32'd0);
      cyc();
      pres(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("alu_stall_c1", {31'b0, stall}, B_STALL);
      chk("alu_pend5_c1", {31'b0, pend_mask[5]}, 32'd1);
      cyc();
      chk("alu_stall_c2", {31'b0, stall}, 32'd0);
      chk("alu_pend5_c2", {31'b0, pend_mask[5]}, 32'd0);
      cyc();
      drain("drain_b");

      // LW r0 then ADD r3,r0,r0
      pres(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lw_r0_stall", {31'b0, stall}, 32'd0);
      cyc();
      pres(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("r0_use_stall", {31'b0, stall}, 32'd0);
      chk("r0_pend", pend_mask, 32'h0);
      cyc();
      drain("drain_c");

      // Flushed DIV must not start the unit
      pres(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc();
      nop();
      chk("flush_div_busy", {31'b0, div_busy}, 32'd0);

      // DIV then MFLO; second DIV at cycle 5
      pres(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("div_fire_stall", {31'b0, stall}, 32'd0);
      chk("div_c0_busy", {31'b0, div_busy}, 32'd0);
      cyc();
      for (int c = 1; c <= 33; c++) begin
         if (c == 5)
            pres(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         else
            pres(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("div_stall_c%0d", c), {31'b0, stall}, (c <= 32) ? 32'd1 : 32'd0);
         chk($sformatf("div_busy_c%0d", c), {31'b0, div_busy}, (c <= 32) ? 32'd1 : 32'd0);
         chk($sformatf("div_done_c%0d", c), {31'b0, div_done}, (c == 33) ? 32'd1 : 32'd0);
         cyc();
      end
      nop();
      chk("div_done_c34", {31'b0, div_done}, 32'd0);
      chk("div_busy_c34", {31'b0, div_busy}, 32'd0);
      drain("drain_d");

      // WAW: LW r4, ADD r4,r1,r1, then reader of r4
      pres(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      pres(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("waw_add_stall", {31'b0, stall}, 32'd0);
      cyc();
      for (int k = 0; k <= WAW_STALLS; k++) begin
         pres(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("waw_rd_stall_k%0d", k), {31'b0, stall}, (k < WAW_STALLS) ? 32'd1 : 32'd0);
         cyc();
      end
      drain("drain_e");

      // Reset mid-divide with r4 pending
      pres(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      nop();
      repeat (8) cyc();
      pres(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_alu_stall", {31'b0, stall}, 32'd0);
      cyc();
      pres(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mid_pend", pend_mask, 32'h10);
      chk("mid_busy", {31'b0, div_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'b0, div_busy}, 32'd0);
      chk("arst_pend", pend_mask, 32'h0);
      chk("arst_stall", {31'b0, stall}, 32'd1);
      chk("arst_done", {31'b0, div_done}, 32'd0);
      cyc();
      chk("arst_stall_hold", {31'b0, stall}, 32'd1);
      rst_n = 1'b1;
      #1;
      chk("rel_stall", {31'b0, stall}, 32'd0);

      // Flushed LW r7 leaves no pending write
      pres(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("flush_lw_stall", {31'b0, stall}, 32'd0);
      cyc();
      nop();
      chk("flush_lw_pend", pend_mask, 32'h0);
      chk("flush_lw_busy", {31'b0, div_busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
